// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter and its helpers.
package vram_pkg;

  localparam int unsigned VID_AW  = 13;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Video, CPU and RAM-macro signals around the VRAM arbiter.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
);

  logic              vid_req;
  logic [VID_AW-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_wait;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_ack, vid_data, cpu_rdata, cpu_ack, cpu_wait, ram_addr, ram_we, ram_wdata
  );

  // Requester / RAM side
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_ack, vid_data, cpu_rdata, cpu_ack, cpu_wait, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/vram_starve_guard.sv
// Counts consecutive grants to the high-priority requester while the low-priority one waits,
// and forces the low-priority requester in once the limit is reached.
module vram_starve_guard #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic vid_grant_i,
  input  logic cpu_grant_i,
  input  logic cpu_req_i,
  output logic force_cpu_c
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // A waiting-free idle cycle or a CPU grant ends the starvation run
  always_comb begin
    cnt_d = cnt_q;
    if (cpu_grant_i || (idle_i && !cpu_req_i)) begin
      cnt_d = '0;
    end else if (vid_grant_i && cpu_req_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign force_cpu_c = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Serialises video fetch and CPU accesses onto the single-port VRAM; video has priority,
// with a starvation guard that periodically lets a waiting CPU in.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_vram,
  input  logic          nreset,
  vram_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;

  arb_state_t        state_q,     state_d;
  owner_t            owner_q,     owner_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_we_q,    ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] vid_data_q,  vid_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vid_ack_q,   vid_ack_d;
  logic              cpu_ack_q,   cpu_ack_d;

  logic in_idle_c;
  logic grant_vid_c;
  logic grant_cpu_c;
  logic force_cpu_c;

  vram_starve_guard #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_guard (
    .clk         (clk_vram),
    .rst_n       (nreset),
    .idle_i      (in_idle_c),
    .vid_grant_i (grant_vid_c),
    .cpu_grant_i (grant_cpu_c),
    .cpu_req_i   (bus.cpu_req),
    .force_cpu_c (force_cpu_c)
  );

  // Grant decode: video wins ties unless the CPU has been starved
  always_comb begin
    in_idle_c   = (state_q == IDLE);
    grant_vid_c = 1'b0;
    grant_cpu_c = 1'b0;
    if (in_idle_c) begin
      if (bus.cpu_req && (!bus.vid_req || force_cpu_c)) begin
        grant_cpu_c = 1'b1;
      end else if (bus.vid_req) begin
        grant_vid_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu_c) begin
          owner_d     = OWN_CPU;
          ram_addr_d  = bus.cpu_addr;
          ram_we_d    = bus.cpu_we;
          ram_wdata_d = bus.cpu_wdata;
          cnt_d       = CNT_W'(ACCESS_CYC - 1);
          state_d     = ACCESS;
        end else if (grant_vid_c) begin
          owner_d     = OWN_VID;
          ram_addr_d  = ADDR_W'(bus.vid_addr);
          ram_we_d    = 1'b0;
          cnt_d       = CNT_W'(ACCESS_CYC - 1);
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          ram_we_d = 1'b0;
          state_d  = DONE;
          if (owner_q == OWN_VID) begin
            vid_data_d = bus.ram_rdata;
            vid_ack_d  = 1'b1;
          end else begin
            // Writes leave the CPU's read-back register untouched
            if (!ram_we_q) begin
              cpu_rdata_d = bus.ram_rdata;
            end
            cpu_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_vram or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_VID;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_data_q  <= '0;
      cpu_rdata_q <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed timing/arbitration cases plus random traffic
// checked against a memory-array reference model.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int ADDR_W     = 14;
  localparam int ACCESS_CYC = 2;
  localparam int STARVE_MAX = 4;
  localparam int TMO        = 200;
  localparam int PERIOD     = ACCESS_CYC + 2;
  localparam int VID_BOUND  = (ACCESS_CYC + 2) + (ACCESS_CYC + 1);
  localparam int CPU_BOUND  = (STARVE_MAX + 1) * (ACCESS_CYC + 2) + ACCESS_CYC + 1;

  logic clk_vram = 1'b0;
  logic nreset   = 1'b0;
  always #5 clk_vram = ~clk_vram;

  vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_arbiter #(
    .ADDR_W     (ADDR_W),
    .ACCESS_CYC (ACCESS_CYC),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_vram (clk_vram),
    .nreset   (nreset),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc_n       = 0;

  logic [7:0] ram_mem [0:16383];
  logic [7:0] ref_mem [0:16383];
  logic [7:0] exp_vid_q [$];
  logic [7:0] exp_cpu_q [$];
  logic       ack_log   [$];
  int         ack_cyc   [$];
  logic [7:0] cpu_rd_model = 8'h00;

  function automatic logic [7:0] pattern(input logic [13:0] a);
    return a[7:0] ^ {a[12:8], 3'b000} ^ 8'h8E;
  endfunction

  // Behavioural single-port RAM: combinational read, write on the clock edge
  assign bus.ram_rdata = ram_mem[bus.ram_addr];
  always @(posedge clk_vram) if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
  initial for (int a = 0; a < 16384; a++) ram_mem[a] <= pattern(14'(a));
  initial for (int a = 0; a < 16384; a++) ref_mem[a] = pattern(14'(a));

  always @(posedge clk_vram) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: ack=1 with no outstanding request, expected ack=0", name);
  endtask

  // Monitor: pops the scoreboard on every ack and checks cycle-level invariants
  always @(negedge clk_vram) begin
    if (nreset) begin
      check("cpu_wait", 32'(bus.cpu_wait), 32'(bus.cpu_req & ~bus.cpu_ack));
      if (bus.vid_ack || bus.cpu_ack) check("ram_we_at_ack", 32'(bus.ram_we), 32'd0);
      if (bus.vid_ack) begin
        check("ack_exclusive", 32'(bus.cpu_ack), 32'd0);
        ack_log.push_back(1'b0);
        ack_cyc.push_back(cyc_n);
        if (exp_vid_q.size() == 0) spurious("vid_ack_spurious");
        else check("vid_data", 32'(bus.vid_data), 32'(exp_vid_q.pop_front()));
      end
      if (bus.cpu_ack) begin
        ack_log.push_back(1'b1);
        ack_cyc.push_back(cyc_n);
        if (exp_cpu_q.size() == 0) spurious("cpu_ack_spurious");
        else check("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk_vram);
    #1;
  endtask

  task automatic wait_ack(input bit is_cpu, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < TMO) begin
      step();
      lat++;
      seen = is_cpu ? bus.cpu_ack : bus.vid_ack;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_ack_timeout: no ack after %0d cycles, required an ack",
               is_cpu ? "cpu" : "vid", lat);
    end
  endtask

  task automatic vid_txn(input logic [12:0] addr, input bit exact);
    int lat;
    bus.vid_addr = addr;
    bus.vid_req  = 1'b1;
    exp_vid_q.push_back(ref_mem[14'(addr)]);
    wait_ack(1'b0, lat);
    bus.vid_req = 1'b0;
    if (exact) check("vid_latency", 32'(lat), 32'(ACCESS_CYC + 1));
    else       check("vid_latency_bound", 32'(lat <= VID_BOUND), 32'd1);
  endtask

  task automatic cpu_txn(input bit we, input logic [13:0] addr, input logic [7:0] wdata,
                         input bit exact);
    int lat;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
    if (we) ref_mem[addr] = wdata;
    else    cpu_rd_model  = ref_mem[addr];
    exp_cpu_q.push_back(cpu_rd_model);
    wait_ack(1'b1, lat);
    bus.cpu_req = 1'b0;
    if (exact) check("cpu_latency", 32'(lat), 32'(ACCESS_CYC + 1));
    else       check("cpu_latency_bound", 32'(lat <= CPU_BOUND), 32'd1);
  endtask

  task automatic vid_rand(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) step();
      vid_txn(13'($urandom), 1'b0);
    end
  endtask

  // CPU traffic stays in the upper half so it never races the video reads
  task automatic cpu_rand(input int n);
    logic [13:0] written [$];
    logic [13:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) step();
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = 14'h2000 | 14'($urandom_range(0, 14'h1FFE));
        written.push_back(a);
        cpu_txn(1'b1, a, 8'($urandom), 1'b0);
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        cpu_txn(1'b0, a, 8'h00, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int guard;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // Reset state
    repeat (3) step();
    check("rst_vid_ack",   32'(bus.vid_ack),   32'd0);
    check("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
    check("rst_ram_we",    32'(bus.ram_we),    32'd0);
    check("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
    check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_vid_data",  32'(bus.vid_data),  32'd0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rst_cpu_wait",  32'(bus.cpu_wait),  32'd0);
    nreset = 1'b1;
    repeat (2) step();

    // Single video read: address held for the access, ack after ACCESS_CYC+1 edges
    bus.vid_addr = 13'h0123;
    bus.vid_req  = 1'b1;
    exp_vid_q.push_back(8'hA5);
    for (int k = 1; k <= ACCESS_CYC + 1; k++) begin
      step();
      if (k <= ACCESS_CYC) begin
        check("t1_ram_addr", 32'(bus.ram_addr), 32'h0123);
        check("t1_ram_we",   32'(bus.ram_we),   32'd0);
      end
      check("t1_ack_timing", 32'(bus.vid_ack), 32'(k == ACCESS_CYC + 1));
    end
    bus.vid_req = 1'b0;
    step();
    check("t1_vid_data_hold", 32'(bus.vid_data), 32'hA5);

    // CPU write: ram_we exactly ACCESS_CYC cycles, read-back register untouched
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 14'h1800;
    bus.cpu_wdata = 8'h47;
    bus.cpu_req   = 1'b1;
    ref_mem[14'h1800] = 8'h47;
    exp_cpu_q.push_back(cpu_rd_model);
    for (int k = 1; k <= ACCESS_CYC + 1; k++) begin
      step();
      check("t2_ram_we", 32'(bus.ram_we), 32'(k <= ACCESS_CYC));
      if (k <= ACCESS_CYC) begin
        check("t2_ram_wdata", 32'(bus.ram_wdata), 32'h47);
        check("t2_ram_addr",  32'(bus.ram_addr),  32'h1800);
      end
      check("t2_ack_timing", 32'(bus.cpu_ack), 32'(k == ACCESS_CYC + 1));
    end
    bus.cpu_req = 1'b0;
    step();
    cpu_txn(1'b0, 14'h1800, 8'h00, 1'b1);
    step();

    // CPU drops its request mid-access; pending video follows one period later
    ack_log.delete();
    ack_cyc.delete();
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 14'h1800;
    bus.cpu_req  = 1'b1;
    exp_cpu_q.push_back(cpu_rd_model);
    step();
    bus.cpu_req  = 1'b0;
    bus.vid_addr = 13'h0040;
    bus.vid_req  = 1'b1;
    exp_vid_q.push_back(ref_mem[14'h0040]);
    wait_ack(1'b1, lat);
    check("t6_cpu_latency", 32'(lat + 1), 32'(ACCESS_CYC + 1));
    wait_ack(1'b0, lat);
    bus.vid_req = 1'b0;
    check("t6_vid_after_cpu", 32'(lat), 32'(PERIOD));
    @(negedge clk_vram); #1;
    check("t6_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check("t6_first_cpu",  32'(ack_log[0]), 32'd1);
      check("t6_second_vid", 32'(ack_log[1]), 32'd0);
    end
    step();

    // Reset during a CPU write: ram_we drops asynchronously, no ack afterwards
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 14'h3FFF;
    bus.cpu_wdata = 8'h99;
    bus.cpu_req   = 1'b1;
    exp_cpu_q.push_back(cpu_rd_model);
    step();
    check("t5_we_in_access", 32'(bus.ram_we), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("t5_async_ram_we",   32'(bus.ram_we),   32'd0);
    check("t5_async_ram_addr", 32'(bus.ram_addr), 32'd0);
    exp_cpu_q.delete();
    exp_vid_q.delete();
    cpu_rd_model = 8'h00;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    repeat (2) step();
    check("t5_cpu_rdata_rst", 32'(bus.cpu_rdata), 32'(cpu_rd_model));
    check("t5_vid_data_rst",  32'(bus.vid_data),  32'd0);
    nreset = 1'b1;
    repeat (4) step();
    vid_txn(13'h0123, 1'b1);
    step();

    // Reset while the starvation counter is part-way up
    bus.vid_addr = 13'h0055;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 14'h1800;
    for (int i = 0; i < STARVE_MAX; i++) exp_vid_q.push_back(ref_mem[14'h0055]);
    bus.vid_req = 1'b1;
    bus.cpu_req = 1'b1;
    for (int i = 0; i < STARVE_MAX - 1; i++) wait_ack(1'b0, lat);
    repeat (2) step();
    check("t5b_vid_in_access", 32'(bus.ram_addr), 32'h0055);
    nreset = 1'b0;
    #1;
    exp_vid_q.delete();
    exp_cpu_q.delete();
    cpu_rd_model = 8'h00;
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (2) step();
    nreset = 1'b1;
    repeat (2) step();

    // Both requesters held: STARVE_MAX video grants, then one CPU grant, at full rate
    ack_log.delete();
    ack_cyc.delete();
    for (int i = 0; i < 3 * STARVE_MAX; i++) exp_vid_q.push_back(ref_mem[14'h0055]);
    for (int i = 0; i < 3; i++) exp_cpu_q.push_back(ref_mem[14'h1800]);
    cpu_rd_model = ref_mem[14'h1800];
    bus.vid_req = 1'b1;
    bus.cpu_req = 1'b1;
    n = 0;
    guard = 0;
    while (n < 3 * (STARVE_MAX + 1) && guard < TMO) begin
      step();
      guard++;
      if (bus.vid_ack || bus.cpu_ack) n++;
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk_vram); #1;
    check("t3_ack_count", 32'(ack_log.size()), 32'(3 * (STARVE_MAX + 1)));
    for (int i = 0; i < ack_log.size(); i++) begin
      check("t3_grant_order", 32'(ack_log[i]), 32'((i % (STARVE_MAX + 1)) == STARVE_MAX));
      if (i > 0) check("t3_period", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(PERIOD));
    end
    repeat (3) step();

    // Random concurrent traffic against the reference memory
    fork
      vid_rand(40);
      cpu_rand(40);
    join
    repeat (6) step();
    check("end_vid_queue_empty", 32'(exp_vid_q.size()), 32'd0);
    check("end_cpu_queue_empty", 32'(exp_cpu_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
